// File: rtl/spi_target.sv
// SPI target responder with a 64 x 8 register map, read-only ID register and a local register port.
// Optional feature macro: SPI_TARGET_AUTOINC_EN (MS-bit address auto-increment).
module spi_target #(
    parameter logic [5:0] WHO_AM_I_ADDR = 6'h0F,
    parameter logic [7:0] WHO_AM_I_VAL  = 8'h33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_sck,
    input  logic       spi_csn,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic [5:0] lb_addr,
    input  logic       lb_we,
    input  logic [7:0] lb_wdata,
    output logic [7:0] lb_rdata,
    output logic       wr_stb,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data
);

`ifdef SPI_TARGET_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA
    } state_t;

    state_t state_q, state_d;

    logic       sck_s1, sck_s2, sck_s3;
    logic       csn_s1, csn_s2;
    logic       mosi_s1, mosi_s2;
    logic       sck_rise, sck_fall;

    logic [2:0] bit_cnt;
    logic [6:0] shift_in;
    logic [7:0] shift_out;
    logic [7:0] rx_byte;
    logic       load_pend;
    logic       cmd_rw;
    logic       cmd_ms;
    logic [5:0] addr;
    logic       cmd_done, byte_done, commit;
    logic [7:0] spi_rd, lb_rd;

    logic [7:0] regs [64];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_s3  <= 1'b0;
            csn_s1  <= 1'b1;
            csn_s2  <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sck_s1  <= spi_sck;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            csn_s1  <= spi_csn;
            csn_s2  <= csn_s1;
            mosi_s1 <= spi_mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    assign sck_rise = sck_s2 & ~sck_s3 & ~csn_s2;
    assign sck_fall = ~sck_s2 & sck_s3 & ~csn_s2;
    assign rx_byte  = {shift_in, mosi_s2};

    assign spi_rd = (addr == WHO_AM_I_ADDR) ? WHO_AM_I_VAL : regs[addr];
    assign lb_rd  = (lb_addr == WHO_AM_I_ADDR) ? WHO_AM_I_VAL : regs[lb_addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cmd_done  = 1'b0;
        byte_done = 1'b0;
        if (csn_s2) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_CMD;
                ST_CMD: begin
                    if (sck_rise && bit_cnt == 3'd7) begin
                        cmd_done = 1'b1;
                        state_d  = ST_DATA;
                    end
                end
                ST_DATA: byte_done = sck_rise && (bit_cnt == 3'd7);
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign commit   = byte_done & ~cmd_rw & (addr != WHO_AM_I_ADDR);
    assign spi_miso = (state_q == ST_DATA && cmd_rw) ? shift_out[7] : 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt   <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            load_pend <= 1'b0;
            cmd_rw    <= 1'b0;
            cmd_ms    <= 1'b0;
            addr      <= '0;
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            lb_rdata  <= '0;
            regs      <= '{default: '0};
        end else begin
            wr_stb   <= 1'b0;
            lb_rdata <= lb_rd;
            if (lb_we && lb_addr != WHO_AM_I_ADDR)
                regs[lb_addr] <= lb_wdata;

            if (state_q == ST_IDLE || csn_s2) begin
                bit_cnt   <= '0;
                shift_out <= '0;
                load_pend <= 1'b0;
            end else begin
                if (sck_rise) begin
                    shift_in <= rx_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (cmd_done) begin
                    cmd_rw    <= rx_byte[7];
                    cmd_ms    <= rx_byte[6];
                    addr      <= rx_byte[5:0];
                    load_pend <= 1'b1;
                end
                // SPI commit is placed after the local write so it wins on an address collision
                if (byte_done) begin
                    if (commit) begin
                        regs[addr] <= rx_byte;
                        wr_stb     <= 1'b1;
                        wr_addr    <= addr;
                        wr_data    <= rx_byte;
                    end
                    addr      <= addr + {5'd0, cmd_ms & AUTOINC};
                    load_pend <= 1'b1;
                end
                if (sck_fall && state_q == ST_DATA && cmd_rw) begin
                    if (load_pend) begin
                        shift_out <= spi_rd;
                        load_pend <= 1'b0;
                    end else begin
                        shift_out <= {shift_out[6:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: table of single-byte transfers plus burst, abort, collision and reset sequences.
module tb_spi_target;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spi_sck = 1'b0;
    logic       spi_csn = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic [5:0] lb_addr = '0;
    logic       lb_we = 1'b0;
    logic [7:0] lb_wdata = '0;
    logic [7:0] lb_rdata;
    logic       wr_stb;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;

    int n_checks = 0;
    int n_fail   = 0;
    int stb_cnt  = 0;
    bit mode3    = 1'b0;
    bit lat_chk  = 1'b0;
    bit coll_en  = 1'b0;

    spi_target dut (
        .clk      (clk),
        .reset    (reset),
        .spi_sck  (spi_sck),
        .spi_csn  (spi_csn),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .lb_addr  (lb_addr),
        .lb_we    (lb_we),
        .lb_wdata (lb_wdata),
        .lb_rdata (lb_rdata),
        .wr_stb   (wr_stb),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_stb) stb_cnt++;

    typedef struct {
        logic       m3;
        logic [7:0] cmd;
        logic [7:0] dat;
        logic [7:0] rx;
        int         stb;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hwait();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic lb_write(input logic [5:0] a, input logic [7:0] d);
        lb_addr  = a;
        lb_wdata = d;
        lb_we    = 1'b1;
        @(posedge clk);
        #1;
        lb_we = 1'b0;
    endtask

    task automatic lb_read(input logic [5:0] a, output logic [7:0] d);
        lb_addr = a;
        @(posedge clk);
        #1;
        d = lb_rdata;
    endtask

    task automatic spi_start();
        spi_sck = mode3;
        hwait();
        spi_csn = 1'b0;
        hwait();
    endtask

    task automatic spi_stop();
        hwait();
        spi_csn = 1'b1;
        hwait();
        hwait();
    endtask

    // Master side: mosi changes on the leading fall (mode 3) or after the rise (mode 0); miso sampled before each rise
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            if (mode3) spi_sck = 1'b0;
            spi_mosi = tx[7-i];
            hwait();
            rx[7-i] = spi_miso;
            spi_sck = 1'b1;
            if (i == 7 && (lat_chk || coll_en)) begin
                @(posedge clk);
                @(posedge clk);
                #1;
                if (lat_chk) check("wr_stb_lat2", wr_stb, 1'b0);
                if (coll_en) begin
                    lb_addr  = 6'h10;
                    lb_wdata = 8'h11;
                    lb_we    = 1'b1;
                end
                @(posedge clk);
                #1;
                lb_we = 1'b0;
                if (lat_chk) check("wr_stb_lat3", wr_stb, 1'b1);
                repeat (5) @(posedge clk);
                #1;
            end else begin
                hwait();
            end
            if (!mode3) spi_sck = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] d;
        logic [7:0] exp_burst [3];
        int s0;

        vecs[0] = '{1'b0, 8'h8F, 8'h00, 8'h33, 0};
        vecs[1] = '{1'b0, 8'h20, 8'h57, 8'h00, 1};
        vecs[2] = '{1'b0, 8'hA0, 8'h00, 8'h57, 0};
        vecs[3] = '{1'b0, 8'h0F, 8'h99, 8'h00, 0};
        vecs[4] = '{1'b0, 8'h8F, 8'h00, 8'h33, 0};
        vecs[5] = '{1'b1, 8'h01, 8'h3C, 8'h00, 1};
        vecs[6] = '{1'b1, 8'h81, 8'h00, 8'h3C, 0};
        vecs[7] = '{1'b1, 8'h8F, 8'h00, 8'h33, 0};
        vecs[8] = '{1'b0, 8'h3F, 8'h5A, 8'h00, 1};
        vecs[9] = '{1'b0, 8'hBF, 8'h00, 8'h5A, 0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_miso", spi_miso, 1'b0);
        check("rst_wr_stb", wr_stb, 1'b0);
        check("rst_wr_addr", wr_addr, 6'h00);
        check("rst_wr_data", wr_data, 8'h00);
        check("rst_lb_rdata", lb_rdata, 8'h00);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        for (int k = 0; k < 10; k++) begin
            mode3 = vecs[k].m3;
            s0 = stb_cnt;
            spi_start();
            spi_bits(vecs[k].cmd, 8, rx);
            check("cmd_phase_miso", rx, 8'h00);
            lat_chk = (k == 1);
            spi_bits(vecs[k].dat, 8, rx);
            lat_chk = 1'b0;
            spi_stop();
            check("vec_miso", rx, vecs[k].rx);
            check("vec_stb_cnt", stb_cnt - s0, vecs[k].stb);
            if (vecs[k].stb != 0) begin
                check("vec_wr_addr", wr_addr, vecs[k].cmd[5:0]);
                check("vec_wr_data", wr_data, vecs[k].dat);
            end
        end
        mode3 = 1'b0;

        lb_read(6'h20, d);
        check("lb_rd_20", d, 8'h57);
        lb_read(6'h0F, d);
        check("lb_rd_id", d, 8'h33);
        lb_write(6'h0F, 8'hEE);
        lb_read(6'h0F, d);
        check("lb_id_ro", d, 8'h33);

        // burst read across the 0x3F -> 0x00 wrap
        lb_write(6'h3E, 8'hAA);
        lb_write(6'h3F, 8'hBB);
        lb_write(6'h00, 8'hCC);
`ifdef SPI_TARGET_AUTOINC_EN
        exp_burst = '{8'hAA, 8'hBB, 8'hCC};
`else
        exp_burst = '{8'hAA, 8'hAA, 8'hAA};
`endif
        spi_start();
        spi_bits(8'hFE, 8, rx);
        for (int b = 0; b < 3; b++) begin
            spi_bits(8'h00, 8, rx);
            check("burst_miso", rx, exp_burst[b]);
        end
        spi_stop();

        // abort after four data bits
        lb_write(6'h21, 8'h44);
        s0 = stb_cnt;
        spi_start();
        spi_bits(8'h21, 8, rx);
        spi_bits(8'hF0, 4, rx);
        spi_stop();
        check("abort_stb", stb_cnt - s0, 0);
        lb_read(6'h21, d);
        check("abort_reg", d, 8'h44);
        spi_start();
        spi_bits(8'hA1, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_stop();
        check("post_abort_read", rx, 8'h44);

        // local write and SPI commit to the same address in the same cycle
        s0 = stb_cnt;
        spi_start();
        spi_bits(8'h10, 8, rx);
        coll_en = 1'b1;
        spi_bits(8'h22, 8, rx);
        coll_en = 1'b0;
        spi_stop();
        lb_read(6'h10, d);
        check("collision_reg", d, 8'h22);
        check("collision_stb", stb_cnt - s0, 1);
        check("collision_wr_addr", wr_addr, 6'h10);

        // reset during the third bit of a read data byte (0x3E holds 0xAA, third bit is 1)
        spi_start();
        spi_bits(8'hBE, 8, rx);
        spi_bits(8'h00, 2, rx);
        check("mid_read_bits", rx, 8'h80);
        spi_mosi = 1'b0;
        hwait();
        check("mid_read_miso", spi_miso, 1'b1);
        spi_sck = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_miso", spi_miso, 1'b0);
        check("rst_mid_stb", wr_stb, 1'b0);
        check("rst_mid_lb_rdata", lb_rdata, 8'h00);
        spi_csn = 1'b1;
        spi_sck = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        lb_read(6'h3E, d);
        check("rst_reg_3e", d, 8'h00);
        lb_read(6'h20, d);
        check("rst_reg_20", d, 8'h00);
        spi_start();
        spi_bits(8'h8F, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_stop();
        check("post_rst_id", rx, 8'h33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_target.md
# spi_target

SPI target (peripheral-side responder) for on-board loopback and bring-up of the core's SPI master without the external accelerometer. It implements the same register protocol as the sensor: one command byte followed by data bytes, 64 × 8-bit register map, and a read-only ID register. It sits on the FPGA pins or internally opposite the SoC's spi_sck/spi_csn/spi_mosi/spi_miso. It exposes a local port so test firmware or logic can preload and observe registers.

## Interface
- WHO_AM_I_ADDR, 6'h0F: address of the read-only ID register.
- WHO_AM_I_VAL, 8'h33: value returned at WHO_AM_I_ADDR.
- clk  in  1  system clock; all logic in this domain.
- reset  in  1  asynchronous, active-high reset.
- spi_sck  in  1  SPI clock from master, asynchronous to clk; mode 0 and mode 3 both supported.
- spi_csn  in  1  chip select, active low, asynchronous.
- spi_mosi  in  1  master-to-target data, MSB first.
- spi_miso  out  1  target-to-master data, MSB first.
- lb_addr  in  6  local register address.
- lb_we  in  1  local write strobe.
- lb_wdata  in  8  local write data.
- lb_rdata  out  8  registered read data for lb_addr, 1-cycle latency.
- wr_stb  out  1  one-cycle pulse when an SPI write commits.
- wr_addr  out  6  address of last SPI write.
- wr_data  out  8  data of last SPI write.

## Operation
- spi_sck, spi_csn, spi_mosi pass through 2-FF synchronizers. Rise and fall events on sck come from a third register; sck events are ignored while synchronized csn is high.
- The FSM has three states:
  - IDLE: csn high. Bit counter is 0 and spi_miso is 0.
  - CMD: entered on the csn falling edge. Eight mosi bits are shifted in on sck rises. bit7 = RW (1 = read), bit6 = MS (auto-increment), bits5:0 = address.
  - DATA: entered after the 8th command bit.
- DATA, write (RW = 0):
  - Eight bits are shifted per byte.
  - On the 8th rise, the byte is written to reg[addr]. In the same cycle, wr_stb pulses and wr_addr/wr_data update.
  - A write to WHO_AM_I_ADDR is discarded: no register change, no wr_stb.
- DATA, read (RW = 1):
  - On the first sck fall after each byte boundary (including the command byte), the shift-out register loads reg[addr] and spi_miso = its MSB.
  - On each later sck fall, the register shifts left.
  - A read of WHO_AM_I_ADDR returns WHO_AM_I_VAL.
- During CMD, spi_miso = 0.
- Address advance after each data byte is defined under Configuration. Address arithmetic is 6-bit, so 0x3F wraps to 0x00.
- A csn rise (synchronized) in any state returns the FSM to IDLE:
  - a partial byte is discarded;
  - the bit counter clears;
  - spi_miso goes to 0.
- A new csn fall starts a fresh CMD.
- Local port:
  - lb_we writes reg[lb_addr] on the clk edge; writes to WHO_AM_I_ADDR are ignored.
  - lb_rdata returns reg[lb_addr] (or WHO_AM_I_VAL) one cycle later.
- If an SPI commit and lb_we hit the same address in the same cycle, the SPI write wins.

## Timing
- Reset values:
  - FSM IDLE; bit counter 0; spi_miso 0.
  - wr_stb 0, wr_addr 0, wr_data 0, lb_rdata 0.
  - All registers 0x00.
- Pin-to-event latency is 3 clk. wr_stb asserts 3 clk after the 8th data-bit sck rise at the pin.
- spi_miso changes at most 4 clk after an sck fall at the pin.
- Requirements on the SPI clock and select:
  - sck high and low phases must each be at least 6 clk cycles; this gives MISO setup of at least 2 clk before the next rise.
  - csn setup before the first sck edge and hold after the last sck edge must be at least 4 clk.
- A reset mid-transfer forces reset values immediately. The master must deassert csn before the next transaction.

## Configuration
- SPI_TARGET_AUTOINC_EN defined: when MS = 1, addr increments by 1 (mod 64) after each completed data byte, read or write. When MS = 0, addr stays fixed.
- SPI_TARGET_AUTOINC_EN undefined: the MS bit is ignored and addr never changes within a transaction. A repeated read returns the same register; a repeated write overwrites the same register.

## Test plan
- Read ID: send cmd 0x8F, then one data byte → MISO byte = 0x33; no wr_stb.
- Single write: send cmd 0x20, data 0x57 → wr_stb once, wr_addr = 0x20, wr_data = 0x57; lb_addr = 0x20 then gives lb_rdata = 0x57.
- Burst read with wrap (macro defined): preload 0x3E = 0xAA, 0x3F = 0xBB, 0x00 = 0xCC; send cmd 0xFE plus 3 bytes → MISO 0xAA, 0xBB, 0xCC. With the macro undefined, the same stimulus → 0xAA, 0xAA, 0xAA.
- Abort: send cmd 0x21, then 4 data bits, then raise csn → no wr_stb, reg[0x21] unchanged; next transaction (cmd 0xA1 + 1 data byte) works normally.
- Collision: lb_we to 0x10 with 0x11 in the same clk as an SPI commit of 0x22 to 0x10 → reg[0x10] = 0x22.
- Reset mid-read: assert reset during the 3rd bit of a read data byte → spi_miso = 0, wr_stb = 0, registers 0x00; after release, cmd 0x8F reads 0x33.
